// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - S=R=1 policy enum and the shared SR next-state function.
package sr_pkg;

  typedef enum logic [1:0] {
    SR_HOLD     = 2'd0,
    SR_SET_PRIO = 2'd1,
    SR_RST_PRIO = 2'd2,
    SR_TOGGLE   = 2'd3
  } sr_mode_e;

  function automatic logic sr_next(input sr_mode_e mode, input logic q,
                                   input logic s, input logic r);
    logic nq;
    nq = q;
    unique case ({s, r})
      2'b00: nq = q;
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      default: begin
        unique case (mode)
          SR_SET_PRIO: nq = 1'b1;
          SR_RST_PRIO: nq = 1'b0;
          SR_TOGGLE:   nq = ~q;
          default:     nq = q;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - one clocked SR channel with registered conflict flag.
module sr_cell
  import sr_pkg::*;
#(
  parameter sr_mode_e MODE      = SR_HOLD,
  parameter logic     RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic conflict
);

  if (!(MODE inside {SR_HOLD, SR_SET_PRIO, SR_RST_PRIO, SR_TOGGLE})) begin : g_bad_mode
    $error("sr_cell: unsupported MODE");
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Q        <= RESET_VAL;
      conflict <= 1'b0;
    end else if (en) begin
      Q        <= sr_next(MODE, Q, S, R);
      conflict <= S & R;
    end else begin
      conflict <= 1'b0;
    end
  end

endmodule

// File: rtl/sr_ff_bank.sv
// rtl/sr_ff_bank.sv - WIDTH independent SR flip-flops with conflict flags.
// SR_FF_BANK_CNT_EN adds cnt_clr and a saturating conflict_cnt debug counter.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter sr_mode_e         MODE      = SR_HOLD,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
`ifdef SR_FF_BANK_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] conflict_cnt,
`endif
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_any
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE      (MODE),
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clock    (clock),
      .reset    (reset),
      .en       (en),
      .S        (S[i]),
      .R        (R[i]),
      .Q        (Q[i]),
      .conflict (conflict[i])
    );
  end

  assign Qn = ~Q;

  // Computed from inputs rather than from conflict[] so it lands on the same edge.
  logic hit;
  assign hit = en & (|(S & R));

  always_ff @(posedge clock) begin
    if (reset) conflict_any <= 1'b0;
    else       conflict_any <= hit;
  end

`ifdef SR_FF_BANK_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || cnt_clr)
      conflict_cnt <= '0;
    else if (hit && (conflict_cnt != {CNT_W{1'b1}}))
      conflict_cnt <= conflict_cnt + 1'b1;
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
